// File: rtl/cpu_lsu_v2.sv
// Load/store unit: CPU access -> valid/ready bus, with sub-word lanes, extension, misalign and timeout errors.
// Latency: req -> bus_valid next cycle, done one cycle after bus_ready; bus wait states stall the FSM, cpu_req ignored while busy.
module cpu_lsu_v2 #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_size,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_err,
  output logic [1:0]            cpu_err_code,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
  state_t state, state_nxt;

  logic                  lat_we;
  logic [2:0]            lat_size;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [CW-1:0]         wait_cnt;
  logic                  req_illegal;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] lane_shift;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [3:0]            be_lat;
  logic [DATA_WIDTH-1:0] wdata_rep;

  always_comb begin
    req_illegal = 1'b0;
    case (cpu_size)
      3'b000, 3'b100: req_illegal = 1'b0;
      3'b001, 3'b101: req_illegal = cpu_addr[0];
      3'b010:         req_illegal = |cpu_addr[1:0];
      default:        req_illegal = 1'b1;
    endcase
    // unsigned sizes only make sense for loads
    if (cpu_we && cpu_size[2]) req_illegal = 1'b1;
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  assign lane_shift = bus_rdata >> {lat_addr[1:0], 3'b000};

  always_comb begin
    load_ext = bus_rdata;
    case (lat_size)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane_shift[7]}}, lane_shift[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane_shift[15]}}, lane_shift[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane_shift[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane_shift[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  always_comb begin
    be_lat    = 4'b1111;
    wdata_rep = lat_wdata;
    case (lat_size[1:0])
      2'b00: begin
        be_lat    = 4'b0001 << lat_addr[1:0];
        wdata_rep = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        be_lat    = 4'b0011 << lat_addr[1:0];
        wdata_rep = {2{lat_wdata[15:0]}};
      end
      default: begin
        be_lat    = 4'b1111;
        wdata_rep = lat_wdata;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_busy  = 1'b0;
    cpu_done  = 1'b0;
    cpu_err   = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = 4'b0000;
    bus_wdata = '0;
    case (state)
      IDLE: begin
        if (cpu_req) state_nxt = req_illegal ? ERR : ACCESS;
      end
      ACCESS: begin
        cpu_busy  = 1'b1;
        bus_valid = 1'b1;
        bus_we    = lat_we;
        bus_addr  = {lat_addr[ADDR_WIDTH-1:2], 2'b00};
        bus_be    = be_lat;
        bus_wdata = wdata_rep;
        if (bus_ready)        state_nxt = RESP;
        else if (timeout_hit) state_nxt = ERR;
      end
      RESP: begin
        cpu_busy  = 1'b1;
        cpu_done  = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        cpu_busy  = 1'b1;
        cpu_err   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lat_we       <= 1'b0;
      lat_size     <= 3'b000;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      wait_cnt     <= '0;
      cpu_rdata    <= '0;
      cpu_err_code <= 2'b00;
    end else begin
      if (state == IDLE && cpu_req) begin
        lat_we    <= cpu_we;
        lat_size  <= cpu_size;
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
        if (req_illegal) cpu_err_code <= 2'b01;
      end
      // counter only runs while staying in ACCESS, so it never passes TIMEOUT_CYCLES-1
      if (state == ACCESS && state_nxt == ACCESS) begin
        if (TIMEOUT_CYCLES != 0) wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (state == ACCESS && !bus_ready && timeout_hit) cpu_err_code <= 2'b10;
      if (state == ACCESS && bus_ready && !lat_we)      cpu_rdata    <= load_ext;
    end
  end

endmodule

// File: tb/tb_cpu_lsu_v2.sv
// Bench for cpu_lsu_v2: directed cases from the access rules plus a randomized run against a byte-level model.
module tb_cpu_lsu_v2;
  localparam int TO = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_busy, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_err_code;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_rdata;
  logic [1:0]  m_code;

  int          fv, nv, dc, ec;
  logic [31:0] oa, ow, ord;
  logic [3:0]  ob;
  logic        owe;
  logic [1:0]  oc;
  bit          uns, b1;

  always #5 sys_clk = ~sys_clk;

  cpu_lsu_v2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err), .cpu_err_code(cpu_err_code),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_legal(input logic we, input logic [2:0] s, input logic [31:0] a);
    int n = nbytes(s);
    if (n == 0) return 0;
    if (we && s >= 3'd4) return 0;
    return (a % n) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    int v = ((1 << nbytes(s)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] s, input logic [31:0] wd);
    logic [31:0] r;
    int n = nbytes(s);
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
    int n = nbytes(s);
    longint unsigned u, lim;
    if (n == 4) return rd;
    u   = 64'(rd) >> (8 * (a % 4));
    lim = 64'd1 << (8 * n);
    u   = u % lim;
    if (s < 3'd4 && u >= lim / 2) u = u + (64'd1 << 32) - lim;
    return u[31:0];
  endfunction

  // Issues one request and plays a bus that answers after 'waits' wait cycles.
  task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdat, input int waits,
                           input bit noise);
    fv = 0; nv = 0; dc = 0; ec = 0; uns = 0; b1 = 0;
    oa = '0; ow = '0; ob = '0; owe = 1'b0; ord = '0; oc = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    bus_ready = 1'b0;
    step();
    cpu_req = 1'b0;
    b1 = cpu_busy;
    for (int c = 1; c <= 60; c++) begin
      if (noise) begin
        cpu_req = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = 1'($urandom);
        cpu_size = 3'($urandom);
      end
      if (bus_valid === 1'b1) begin
        nv++;
        if (nv == 1) begin
          fv = c; oa = bus_addr; ow = bus_wdata; ob = bus_be; owe = bus_we;
        end else if (bus_addr !== oa || bus_wdata !== ow || bus_be !== ob || bus_we !== owe) begin
          uns = 1;
        end
        bus_ready = (nv > waits);
        bus_rdata = bus_ready ? rdat : $urandom;
      end else begin
        bus_ready = noise ? 1'($urandom) : 1'b0;
        bus_rdata = $urandom;
      end
      if (cpu_done === 1'b1) begin dc = c; break; end
      if (cpu_err === 1'b1)  begin ec = c; break; end
      step();
    end
    ord = cpu_rdata; oc = cpu_err_code;
    cpu_req = 1'b0; bus_ready = 1'b0;
    step();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 3'd0; cpu_addr = '0;
    cpu_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    repeat (3) step();
    tests++;
    if ({cpu_busy, cpu_done, cpu_err, cpu_rdata, cpu_err_code} !== '0) begin
      fails++; $display("FAIL reset_cpu_side: got %h want 0", {cpu_busy, cpu_done, cpu_err, cpu_rdata, cpu_err_code});
    end
    tests++;
    if ({bus_valid, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
      fails++; $display("FAIL reset_bus_side: got %h want 0", {bus_valid, bus_we, bus_addr, bus_be, bus_wdata});
    end
    sys_rst = 1'b0;
    m_rdata = '0; m_code = 2'b00;
    step();
  endtask

  task automatic test_load_word();
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    tests++; if (fv !== 1)   begin fails++; $display("FAIL lw_valid_cycle: got %0d want 1", fv); end
    tests++; if (b1 !== 1)   begin fails++; $display("FAIL lw_busy: got %0d want 1", b1); end
    tests++; if (ob !== 4'b1111 || oa !== 32'h100 || owe !== 1'b0) begin
      fails++; $display("FAIL lw_bus: got be %b addr %h we %b want 1111 100 0", ob, oa, owe);
    end
    tests++; if (dc !== 2)   begin fails++; $display("FAIL lw_done_cycle: got %0d want 2", dc); end
    tests++; if (ord !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata: got %h want deadbeef", ord); end
  endtask

  task automatic test_byte_loads();
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0);
    tests++; if (ob !== 4'b1000 || oa !== 32'h100) begin
      fails++; $display("FAIL lb_bus: got be %b addr %h want 1000 100", ob, oa);
    end
    tests++; if (ord !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_rdata: got %h want ffffff80", ord); end
    do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 0);
    tests++; if (ord !== 32'h00000080) begin fails++; $display("FAIL lbu_rdata: got %h want 00000080", ord); end
    m_rdata = 32'h00000080;
  endtask

  task automatic test_store_half();
    do_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 0);
    tests++; if (oa !== 32'h200 || ob !== 4'b1100 || owe !== 1'b1) begin
      fails++; $display("FAIL sh_bus: got addr %h be %b we %b want 200 1100 1", oa, ob, owe);
    end
    tests++; if (ow !== 32'hABCDABCD) begin fails++; $display("FAIL sh_wdata: got %h want abcdabcd", ow); end
    tests++; if (dc !== 5 || nv !== 4) begin fails++; $display("FAIL sh_timing: got done %0d valid %0d want 5 4", dc, nv); end
    tests++; if (uns !== 0) begin fails++; $display("FAIL sh_stable: got %0d want 0", uns); end
    tests++; if (ord !== m_rdata) begin fails++; $display("FAIL sh_rdata_held: got %h want %h", ord, m_rdata); end
  endtask

  task automatic test_illegal();
    logic [2:0]  sz [3] = '{3'b010, 3'b100, 3'b011};
    logic        wes[3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ads[3] = '{32'h102, 32'h100, 32'h100};
    for (int i = 0; i < 3; i++) begin
      do_access(wes[i], sz[i], ads[i], 32'h55, 32'h0, 0, 0);
      tests++; if (ec !== 1 || nv !== 0 || dc !== 0) begin
        fails++; $display("FAIL illegal_%0d: got err %0d valid %0d done %0d want 1 0 0", i, ec, nv, dc);
      end
      tests++; if (oc !== 2'b01) begin fails++; $display("FAIL illegal_code_%0d: got %b want 01", i, oc); end
    end
    m_code = 2'b01;
  endtask

  task automatic test_timeout();
    do_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1000, 0);
    tests++; if (nv !== TO || ec !== TO + 1) begin
      fails++; $display("FAIL timeout_len: got valid %0d err %0d want %0d %0d", nv, ec, TO, TO + 1);
    end
    tests++; if (oc !== 2'b10) begin fails++; $display("FAIL timeout_code: got %b want 10", oc); end
    do_access(1'b0, 3'b010, 32'h44, 32'h0, 32'h13572468, 1, 0);
    tests++; if (dc !== 3 || ord !== 32'h13572468) begin
      fails++; $display("FAIL after_timeout: got done %0d rdata %h want 3 13572468", dc, ord);
    end
    tests++; if (cpu_err_code !== 2'b10) begin fails++; $display("FAIL code_held: got %b want 10", cpu_err_code); end
    m_rdata = 32'h13572468; m_code = 2'b10;
  endtask

  task automatic test_reset_mid_access();
    bit late = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 3'b010; cpu_addr = 32'h80; bus_ready = 1'b0;
    step();
    cpu_req = 1'b0;
    step();
    tests++; if (bus_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_valid: got %b want 1", bus_valid); end
    sys_rst = 1'b1;
    step();
    tests++;
    if ({cpu_busy, cpu_done, cpu_err, cpu_rdata, cpu_err_code, bus_valid, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: got %h want 0",
                        {cpu_busy, cpu_done, cpu_err, cpu_rdata, cpu_err_code, bus_valid, bus_we, bus_addr, bus_be, bus_wdata});
    end
    sys_rst = 1'b0; bus_ready = 1'b1; bus_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cpu_done !== 1'b0 || cpu_err !== 1'b0 || bus_valid !== 1'b0 || cpu_rdata !== 32'h0) late = 1;
    end
    bus_ready = 1'b0;
    tests++; if (late !== 0) begin fails++; $display("FAIL rst_late_ready: got %0d want 0", late); end
    m_rdata = '0; m_code = 2'b00;
  endtask

  task automatic test_random();
    for (int it = 0; it < 80; it++) begin
      logic        we    = 1'($urandom);
      logic [2:0]  size  = 3'($urandom_range(0, 7));
      logic [31:0] addr  = $urandom;
      logic [31:0] wdata = $urandom;
      logic [31:0] rdat  = $urandom;
      int          waits = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      do_access(we, size, addr, wdata, rdat, waits, 1);
      if (!m_legal(we, size, addr)) begin
        m_code = 2'b01;
        tests++; if (ec !== 1 || nv !== 0 || oc !== m_code) begin
          fails++; $display("FAIL rnd_illegal_%0d: got err %0d valid %0d code %b want 1 0 %b", it, ec, nv, oc, m_code);
        end
      end else if (waits >= TO) begin
        m_code = 2'b10;
        tests++; if (ec !== TO + 1 || nv !== TO || oc !== m_code) begin
          fails++; $display("FAIL rnd_timeout_%0d: got err %0d valid %0d code %b", it, ec, nv, oc);
        end
      end else begin
        if (!we) m_rdata = m_load(size, addr, rdat);
        tests++; if (dc !== waits + 2 || nv !== waits + 1 || fv !== 1 || uns !== 0) begin
          fails++; $display("FAIL rnd_timing_%0d: got done %0d valid %0d first %0d unstable %0d want %0d %0d 1 0",
                            it, dc, nv, fv, uns, waits + 2, waits + 1);
        end
        tests++; if (oa !== (addr & 32'hFFFFFFFC) || ob !== m_be(size, addr) || owe !== we) begin
          fails++; $display("FAIL rnd_bus_%0d: got addr %h be %b we %b want %h %b %b",
                            it, oa, ob, owe, addr & 32'hFFFFFFFC, m_be(size, addr), we);
        end
        if (we) begin
          tests++; if (ow !== m_wdata(size, wdata)) begin
            fails++; $display("FAIL rnd_wdata_%0d: got %h want %h", it, ow, m_wdata(size, wdata));
          end
        end
        tests++; if (ord !== m_rdata || oc !== m_code) begin
          fails++; $display("FAIL rnd_rdata_%0d: got %h code %b want %h %b", it, ord, oc, m_rdata, m_code);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_byte_loads();
    test_store_half();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
